// File: rtl/uart_frame_defs_pkg.sv
// Shared definitions for the UART frame parser: SOF default, FSM state encoding,
// checksum width, statistics counter width and the checksum accumulate helper.
package uart_frame_defs;

    localparam logic [7:0] SOF_DEFAULT = 8'h55;
    localparam int         BYTE_W      = 8;
    localparam int         CSUM_W      = 8;
    localparam int         ERR_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
        return acc + CSUM_W'(b);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x byte RAM, synchronous write, registered read that holds
// its output until the next read enable.
module uart_frame_buf
    import uart_frame_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [BYTE_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [BYTE_W-1:0] o_rd_data
);

    logic [BYTE_W-1:0] r_mem [0:DEPTH-1];
    logic [BYTE_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register drives out_data directly, so it is cleared with the parser.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles SOF|LEN|PAYLOAD|CSUM frames from UART byte strobes and replays verified payloads
// on a valid/ready stream. Optional UART_FRAME_STATS_EN adds the saturating err_cnt output.
module uart_rx_frame_parser
    import uart_frame_defs::*;
#(
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
`ifdef UART_FRAME_STATS_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic       busy,
    output logic       crc_err,
    output logic       len_err,
    output logic       tmo_err,
    output logic       ovf_err
);

    localparam int            AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t            r_state, w_next;
    logic [7:0]        r_len, r_idx, r_rd_idx;
    logic [CSUM_W-1:0] r_sum;
    logic [TW-1:0]     r_timer;
    logic              r_out_last;
    logic              r_crc_err, r_len_err, r_tmo_err, r_ovf_err;

    logic              w_in_frame, w_expire, w_len_bad, w_sum_ok;
    logic              w_pay_last, w_last_beat, w_accept;
    logic              w_wr_en, w_rd_en;
    logic [AW-1:0]     w_rd_addr;
    logic [7:0]        w_rd_data;
    logic              w_crc, w_len, w_tmo, w_ovf;

    assign w_in_frame  = r_state inside {ST_LEN, ST_PAYLOAD, ST_CSUM};
    assign w_expire    = w_in_frame && !rx_done && (r_timer == TMO_LAST);
    assign w_len_bad   = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign w_sum_ok    = (csum_add(r_sum, rx_data) == '0);
    assign w_pay_last  = (r_idx == r_len - 8'd1);
    assign w_last_beat = (r_rd_idx == r_len - 8'd1);
    assign w_accept    = (r_state == ST_DRAIN) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (rx_done && rx_data == SOF_BYTE) w_next = ST_LEN;
            ST_LEN:     if (rx_done) w_next = w_len_bad ? ST_IDLE : ST_PAYLOAD;
                        else if (w_expire) w_next = ST_IDLE;
            ST_PAYLOAD: if (rx_done && w_pay_last) w_next = ST_CSUM;
                        else if (w_expire) w_next = ST_IDLE;
            ST_CSUM:    if (rx_done) w_next = w_sum_ok ? ST_DRAIN : ST_IDLE;
                        else if (w_expire) w_next = ST_IDLE;
            ST_DRAIN:   if (w_accept && w_last_beat) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Buffer fetch-ahead: byte 0 is read on the good CSUM strobe, byte n+1 on acceptance of byte n.
    always_comb begin
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        w_crc     = 1'b0;
        w_len     = 1'b0;
        w_tmo     = 1'b0;
        w_ovf     = 1'b0;
        case (r_state)
            ST_LEN: begin
                w_len = rx_done && w_len_bad;
                w_tmo = w_expire;
            end
            ST_PAYLOAD: begin
                w_wr_en = rx_done;
                w_tmo   = w_expire;
            end
            ST_CSUM: begin
                w_crc   = rx_done && !w_sum_ok;
                w_rd_en = rx_done && w_sum_ok;
                w_tmo   = w_expire;
            end
            ST_DRAIN: begin
                w_ovf     = rx_done;
                w_rd_en   = out_ready && !w_last_beat;
                w_rd_addr = AW'(r_rd_idx + 8'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer    <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_rd_idx   <= '0;
            r_out_last <= 1'b0;
            r_crc_err  <= 1'b0;
            r_len_err  <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_crc_err <= w_crc;
            r_len_err <= w_len;
            r_tmo_err <= w_tmo;
            r_ovf_err <= w_ovf;
            if (rx_done || !w_in_frame) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end
            if (r_state == ST_LEN && rx_done && !w_len_bad) begin
                r_len <= rx_data;
                r_sum <= CSUM_W'(rx_data);
                r_idx <= '0;
            end
            if (w_wr_en) begin
                r_sum <= csum_add(r_sum, rx_data);
                r_idx <= r_idx + 8'd1;
            end
            if (w_rd_en) begin
                if (r_state == ST_CSUM) begin
                    r_rd_idx   <= '0;
                    r_out_last <= (r_len == 8'd1);
                end else begin
                    r_rd_idx   <= r_rd_idx + 8'd1;
                    r_out_last <= (r_rd_idx + 8'd2 == r_len);
                end
            end else if (w_accept) begin
                r_out_last <= 1'b0;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_idx[AW-1:0]),
        .i_wr_data (rx_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

`ifdef UART_FRAME_STATS_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((w_crc || w_len || w_tmo || w_ovf) && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign out_data  = w_rd_data;
    assign out_valid = (r_state == ST_DRAIN);
    assign out_last  = r_out_last;
    assign frame_len = r_len;
    assign busy      = (r_state != ST_IDLE);
    assign crc_err   = r_crc_err;
    assign len_err   = r_len_err;
    assign tmo_err   = r_tmo_err;
    assign ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: vector table, hand-written corner sequences and a
// randomized frame stream checked against a queue-based payload model.
module tb_uart_rx_frame_parser;

    localparam int ML = 16;
    localparam int T  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data, frame_len;
    logic       out_valid, out_last, busy, crc_err, len_err, tmo_err, ovf_err;
`ifdef UART_FRAME_STATS_EN
    logic [15:0] err_cnt;
    int          err_base = 0;
`endif

    always #5 clk = ~clk;

    uart_rx_frame_parser #(
        .SOF_BYTE    (8'h55),
        .MAX_LEN     (ML),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_len (frame_len),
`ifdef UART_FRAME_STATS_EN
        .err_cnt   (err_cnt),
`endif
        .busy      (busy),
        .crc_err   (crc_err),
        .len_err   (len_err),
        .tmo_err   (tmo_err),
        .ovf_err   (ovf_err)
    );

    typedef struct {
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] csum;
        bit         calc;
        int         exp_nout;
        int         exp_crc;
        int         exp_len;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];

    int n_cmp = 0;
    int n_fail = 0;

    // Monitor state, written only by the monitor process.
    logic [7:0] got_q [$];
    bit         got_last [$];
    logic [7:0] got_flen [$];
    int         n_crc = 0, n_len = 0, n_tmo = 0, n_ovf = 0;
    int         excl_bad = 0, hold_bad = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00, prev_flen = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(out_valid && out_data == prev_data &&
                                out_last == prev_last && frame_len == prev_flen))
                hold_bad++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last.push_back(out_last);
                got_flen.push_back(frame_len);
            end
            n_crc += int'(crc_err);
            n_len += int'(len_err);
            n_tmo += int'(tmo_err);
            n_ovf += int'(ovf_err);
            if (int'(crc_err) + int'(len_err) + int'(tmo_err) + int'(ovf_err) > 1)
                excl_bad++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            prev_flen  = frame_len;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_tx(input int gap);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i]);
            if (i != tx_q.size() - 1) repeat (gap) @(posedge clk);
        end
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        out_ready = 1'b1;
        check("drain_done_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef UART_FRAME_STATS_EN
        err_base = n_crc + n_len + n_tmo + n_ovf;
        check("stats_after_rst", int'(err_cnt), 0);
`endif
    endtask

    task automatic run_vec(input int vi);
        vec_t       v;
        logic [7:0] sum, b;
        int         b0, c0, l0, e0, act;
        v = vecs[vi];
        tx_q.delete();
        tx_q.push_back(8'h55);
        tx_q.push_back(v.len);
        if (v.exp_len == 0) begin
            sum = v.len;
            for (int i = 0; i < int'(v.len); i++) begin
                b = v.base + 8'(i) * v.step;
                tx_q.push_back(b);
                sum = sum + b;
            end
            tx_q.push_back(v.calc ? 8'h00 - sum : v.csum);
        end
        b0 = got_q.size();
        c0 = n_crc; l0 = n_len; e0 = n_tmo + n_ovf;
        send_tx(1);
        wait_idle(200, 1'b0);
        check($sformatf("v%0d_nout", vi), got_q.size() - b0, v.exp_nout);
        check($sformatf("v%0d_crc_err", vi), n_crc - c0, v.exp_crc);
        check($sformatf("v%0d_len_err", vi), n_len - l0, v.exp_len);
        check($sformatf("v%0d_other_err", vi), n_tmo + n_ovf - e0, 0);
        for (int i = 0; i < v.exp_nout; i++) begin
            b   = v.base + 8'(i) * v.step;
            act = (b0 + i < got_q.size()) ? int'(got_q[b0 + i]) : -1;
            check($sformatf("v%0d_byte%0d", vi, i), act, int'(b));
            act = (b0 + i < got_q.size()) ? int'(got_last[b0 + i]) : -1;
            check($sformatf("v%0d_last%0d", vi, i), act, (i == v.exp_nout - 1) ? 1 : 0);
            act = (b0 + i < got_q.size()) ? int'(got_flen[b0 + i]) : -1;
            check($sformatf("v%0d_flen%0d", vi, i), act, int'(v.len));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         b0, c0, l0, t0, o0, cnt, ec, el, kind, nn;
        logic [7:0] len, sum, b, cs;

        vecs[0] = '{8'h02, 8'h10, 8'h10, 8'hCE, 1'b0, 2, 0, 0};
        vecs[1] = '{8'h02, 8'h10, 8'h10, 8'hCF, 1'b0, 0, 1, 0};
        vecs[2] = '{8'h02, 8'h10, 8'h10, 8'hCE, 1'b0, 2, 0, 0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 0, 1};
        vecs[4] = '{8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 0, 0, 1};
        vecs[5] = '{8'h10, 8'h01, 8'h03, 8'h00, 1'b1, 16, 0, 0};
        vecs[6] = '{8'h01, 8'h55, 8'h00, 8'h00, 1'b1, 1, 0, 0};
        vecs[7] = '{8'h03, 8'hFF, 8'h80, 8'h00, 1'b1, 3, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_frame_len", int'(frame_len), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_errs", int'({crc_err, len_err, tmo_err, ovf_err}), 0);
        rst = 1'b0;

        for (int vi = 0; vi < 8; vi++) run_vec(vi);

        // Inter-byte timeout: error exactly T cycles after the last byte.
        t0 = n_tmo; b0 = got_q.size();
        tx_q = '{8'h55, 8'h03, 8'h01};
        send_tx(1);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!tmo_err && cnt < T + 10);
        check("tmo_latency", cnt, T);
        check("tmo_busy_after", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check("tmo_pulse_count", n_tmo - t0, 1);

        // Byte landing on the expiry cycle wins.
        t0 = n_tmo; b0 = got_q.size();
        tx_q = '{8'h55, 8'h03, 8'h01};
        send_tx(1);
        repeat (T - 2) @(posedge clk);
        send_byte(8'h02);
        repeat (3) @(posedge clk);
        #1;
        check("tmo_edge_no_err", n_tmo - t0, 0);
        check("tmo_edge_busy", int'(busy), 1);
        tx_q = '{8'h03, 8'hF7};
        send_tx(1);
        wait_idle(100, 1'b0);
        check("tmo_edge_nout", got_q.size() - b0, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("tmo_edge_byte%0d", i),
                  (b0 + i < got_q.size()) ? int'(got_q[b0 + i]) : -1, i + 1);

        // Stray byte in IDLE is ignored.
        c0 = n_crc + n_len + n_tmo + n_ovf;
        send_byte(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        check("stray_busy", int'(busy), 0);
        check("stray_errs", n_crc + n_len + n_tmo + n_ovf - c0, 0);

        // Backpressure with an overrun byte during DRAIN.
        b0 = got_q.size(); o0 = n_ovf;
        out_ready = 1'b0;
        tx_q = '{8'h55, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        send_tx(1);
        check("bp_valid_before_csum", int'(out_valid), 0);
        send_byte(8'h52);
        check("bp_valid_latency", int'(out_valid), 1);
        check("bp_first_data", int'(out_data), 8'h11);
        repeat (10) @(posedge clk);
        #1;
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_data", int'(out_data), 8'h11);
        check("bp_hold_last", int'(out_last), 0);
        check("bp_hold_flen", int'(frame_len), 4);
        send_byte(8'h55);
        repeat (2) @(posedge clk);
        #1;
        check("bp_ovf_pulse", n_ovf - o0, 1);
        check("bp_ovf_data", int'(out_data), 8'h11);
        wait_idle(300, 1'b1);
        check("bp_nout", got_q.size() - b0, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_byte%0d", i),
                  (b0 + i < got_q.size()) ? int'(got_q[b0 + i]) : -1, (i + 1) * 8'h11);
        b0 = got_q.size(); c0 = n_crc + n_len + n_tmo + n_ovf;
        tx_q = '{8'h02, 8'h10, 8'h20, 8'hCE};
        send_tx(1);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sof_forgotten_nout", got_q.size() - b0, 0);
        check("ovf_sof_forgotten_busy", int'(busy), 0);
        check("ovf_sof_forgotten_errs", n_crc + n_len + n_tmo + n_ovf - c0, 0);

        // Reset mid-PAYLOAD.
        b0 = got_q.size();
        tx_q = '{8'h55, 8'h04, 8'h01, 8'h02};
        send_tx(1);
        do_reset();
        check("rstp_busy", int'(busy), 0);
        check("rstp_valid", int'(out_valid), 0);
        check("rstp_flen", int'(frame_len), 0);
        tx_q = '{8'h03, 8'h04, 8'hF2};
        send_tx(1);
        repeat (3) @(posedge clk);
        #1;
        check("rstp_rest_ignored", got_q.size() - b0, 0);

        // Reset mid-DRAIN.
        out_ready = 1'b0;
        tx_q = '{8'h55, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_tx(1);
        check("rstd_valid_before", int'(out_valid), 1);
        do_reset();
        check("rstd_valid", int'(out_valid), 0);
        check("rstd_data", int'(out_data), 0);
        check("rstd_last", int'(out_last), 0);
        check("rstd_flen", int'(frame_len), 0);
        check("rstd_busy", int'(busy), 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rstd_no_output", got_q.size() - b0, 0);

        // Randomized frame stream against the payload queue model.
        exp_q.delete();
        b0 = got_q.size(); c0 = n_crc; l0 = n_len; t0 = n_tmo + n_ovf;
        ec = 0; el = 0;
        for (int it = 0; it < 40; it++) begin
            nn = $urandom_range(0, 2);
            for (int j = 0; j < nn; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h56;
                send_byte(b);
            end
            kind = $urandom_range(0, 9);
            tx_q.delete();
            tx_q.push_back(8'h55);
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255));
                tx_q.push_back(len);
                el++;
            end else begin
                len = 8'($urandom_range(1, ML));
                tx_q.push_back(len);
                sum = len;
                for (int j = 0; j < int'(len); j++) begin
                    b = 8'($urandom_range(0, 255));
                    tx_q.push_back(b);
                    sum = sum + b;
                    if (kind > 2) exp_q.push_back(b);
                end
                cs = 8'h00 - sum;
                if (kind <= 2) begin
                    cs = cs ^ 8'($urandom_range(1, 255));
                    ec++;
                end
                tx_q.push_back(cs);
            end
            send_tx($urandom_range(0, 3));
            wait_idle(400, 1'b1);
        end
        check("rnd_nout", got_q.size() - b0, exp_q.size());
        foreach (exp_q[i])
            check($sformatf("rnd_byte%0d", i),
                  (b0 + i < got_q.size()) ? int'(got_q[b0 + i]) : -1, int'(exp_q[i]));
        check("rnd_crc_err", n_crc - c0, ec);
        check("rnd_len_err", n_len - l0, el);
        check("rnd_other_err", n_tmo + n_ovf - t0, 0);

        check("err_pulse_exclusive", excl_bad, 0);
        check("stall_hold_stable", hold_bad, 0);
`ifdef UART_FRAME_STATS_EN
        check("stats_total", int'(err_cnt), n_crc + n_len + n_tmo + n_ovf - err_base);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
